nzcv_register: RTL
==================

NZCV_REGISTER -- requirements
Module: nzcv_register

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath operand/result width.
REQ-002 SHALL have iCLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have iRST_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have iEnable  input  1  advance enable; 0 = stall, all state holds.
REQ-005 SHALL have iSetFlags  input  1  current instruction is flag-setting (ADDS/SUBS/ANDS...).
REQ-006 SHALL have iFlagOp  input  2  FLAG_OP_ADD / FLAG_OP_SUB / FLAG_OP_LOGIC / FLAG_OP_NONE.
REQ-007 SHALL have iOperandA, iOperandB  input  WIDTH  ALU operands as presented to the ALU.
REQ-008 SHALL have iResult  input  WIDTH  ALU result.
REQ-009 SHALL have iSave  input  1  copy live NZCV into shadow (exception entry).
REQ-010 SHALL have iRestore  input  1  copy shadow into live NZCV (exception return).
REQ-011 SHALL have oFlagN, oFlagZ, oFlagC, oFlagV  output  1 each  registered live flags for the branch-condition unit.
REQ-012 SHALL have oShadowValid  output  1  shadow holds a saved value.
REQ-013 SHALL have oRestoreErr  output  1  registered one-cycle pulse: restore requested with no valid shadow.

Function
REQ-014 Flag calc SHALL be combinational: N = iResult[WIDTH-1]; Z = (iResult == 0).
REQ-015 ADD: C = carry-out of (WIDTH+1)-bit A+B; V = (A[msb]==B[msb]) & (iResult[msb]!=A[msb]).
REQ-016 SUB: C = carry-out of A + ~B + 1 (1 = no borrow, i.e. A >= B unsigned); V = (A[msb]!=B[msb]) & (iResult[msb]!=A[msb]).
REQ-017 LOGIC: N, Z as REQ-014; C = 0; V = 0.
REQ-018 NONE: live flags SHALL NOT change even if iSetFlags = 1.
REQ-019 Live flags SHALL load calculated NZCV at rising edge when iEnable & iSetFlags & iFlagOp != NONE; otherwise hold.
REQ-020 Latency: flags visible on outputs exactly one cycle after the setting instruction; no combinational path from inputs to outputs.
REQ-021 iSave (with iEnable) SHALL capture the pre-update live NZCV into shadow and set oShadowValid.
REQ-022 iRestore (with iEnable, oShadowValid = 1) SHALL load shadow into live NZCV and clear oShadowValid.
REQ-023 Priority for the live register: iRestore over iSetFlags in the same cycle.
REQ-024 iSave and iRestore together with valid shadow SHALL swap live and shadow; oShadowValid stays 1.
REQ-025 iRestore with oShadowValid = 0 SHALL leave live flags unchanged (unless iSetFlags updates them) and pulse oRestoreErr for one cycle; iSave in that cycle still captures.
REQ-026 oRestoreErr SHALL be 0 in every cycle not following a REQ-025 event, including stalled cycles.
REQ-027 With iEnable = 0 all inputs SHALL be ignored.

Reset
REQ-028 iRST_n low SHALL immediately force N=Z=C=V=0, shadow=0000, oShadowValid=0, oRestoreErr=0, independent of iCLK.
REQ-029 Reset asserted mid-operation SHALL discard any pending save/restore/update; first post-reset edge behaves as from clean state.

Structure
REQ-030 FLAG_OP_ADD=2'b00, FLAG_OP_SUB=2'b01, FLAG_OP_LOGIC=2'b10, FLAG_OP_NONE=2'b11 SHALL live in the shared parameters file, alongside the branch-condition encodings.
REQ-031 Combinational flag calculation SHALL be one sub-module, nzcv_calc; nzcv_register holds live/shadow registers and control.

Verification
REQ-032 ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1, R=0x8000_0000_0000_0000, iSetFlags=1 -> next cycle N=1 Z=0 C=0 V=1.
REQ-033 SUB A=5, B=5, R=0 -> N=0 Z=1 C=1 V=0; then SUB A=3, B=5, R=0xFFFF_FFFF_FFFF_FFFE -> N=1 Z=0 C=0 V=0.
REQ-034 ADD A=B=0xFFFF_FFFF_FFFF_FFFF, R=0xFFFF_FFFF_FFFF_FFFE -> N=1 C=1 V=0; then LOGIC R=0 -> N=0 Z=1 C=0 V=0.
REQ-035 Live=1010, iSave -> shadow valid; SUB sets 0110; iRestore+iSetFlags same cycle -> live=1010, oShadowValid=0.
REQ-036 iRestore with no shadow -> flags unchanged, oRestoreErr=1 one cycle; iEnable=0 with iSetFlags=1 -> no change.
REQ-037 Assert iRST_n low between edges with live=1111, valid shadow -> outputs 0000, oShadowValid=0 before next edge.

Source files
------------

// File: rtl/nzcv_register_pkg.sv
// Shared encodings for the flag unit and the branch-condition unit.
//   flagOp_e : ALU flag-update operation presented alongside the result.
//   cond_e   : A64-style branch condition codes evaluated against NZCV.
//   nzcv_t   : packed {n, z, c, v} flag group.
//   condPass : evaluates a condition code against a flag group.
package nzcv_register_pkg;

  typedef enum logic [1:0] {
    FLAG_OP_ADD   = 2'b00,
    FLAG_OP_SUB   = 2'b01,
    FLAG_OP_LOGIC = 2'b10,
    FLAG_OP_NONE  = 2'b11
  } flagOp_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic logic condPass(input cond_e cond, input nzcv_t f);
    logic base;
    case (cond[3:1])
      3'd0:    base = f.z;
      3'd1:    base = f.c;
      3'd2:    base = f.n;
      3'd3:    base = f.v;
      3'd4:    base = f.c & ~f.z;
      3'd5:    base = (f.n == f.v);
      3'd6:    base = (f.n == f.v) & ~f.z;
      default: base = 1'b1;
    endcase
    // Odd codes invert, except NV which behaves as AL.
    if (cond[0] && (cond != COND_NV)) condPass = ~base;
    else                              condPass = base;
  endfunction

endpackage

// File: rtl/nzcv_calc.sv
// Combinational NZCV calculation from the ALU operands and result.
//   iFlagOp              : flag operation (flagOp_e encoding)
//   iOperandA/iOperandB  : ALU operands as presented to the ALU
//   iResult              : ALU result
//   oFlagN/Z/C/V         : calculated flags (all zero for FLAG_OP_NONE)
module nzcv_calc
  import nzcv_register_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [1:0]       iFlagOp,
  input  logic [WIDTH-1:0] iOperandA,
  input  logic [WIDTH-1:0] iOperandB,
  input  logic [WIDTH-1:0] iResult,
  output logic             oFlagN,
  output logic             oFlagZ,
  output logic             oFlagC,
  output logic             oFlagV
);

  logic msbA, msbB, msbR;
  logic addCarry, subCarry;

  assign msbA = iOperandA[WIDTH-1];
  assign msbB = iOperandB[WIDTH-1];
  assign msbR = iResult[WIDTH-1];

  // A+B carries out of WIDTH bits exactly when A > ~B (unsigned);
  // A+~B+1 carries out exactly when A >= B (no borrow).
  assign addCarry = (iOperandA > ~iOperandB);
  assign subCarry = (iOperandA >= iOperandB);

  always_comb begin
    oFlagN = msbR;
    oFlagZ = (iResult == '0);
    oFlagC = 1'b0;
    oFlagV = 1'b0;
    case (flagOp_e'(iFlagOp))
      FLAG_OP_ADD: begin
        oFlagC = addCarry;
        oFlagV = (msbA == msbB) & (msbR != msbA);
      end
      FLAG_OP_SUB: begin
        oFlagC = subCarry;
        oFlagV = (msbA != msbB) & (msbR != msbA);
      end
      FLAG_OP_LOGIC: ;
      default: begin
        oFlagN = 1'b0;
        oFlagZ = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/nzcv_register.sv
// Live and shadow NZCV flag registers with exception save/restore.
//   iCLK, iRST_n          : clock, asynchronous active-low reset
//   iEnable               : advance enable (0 = stall, everything holds)
//   iSetFlags, iFlagOp    : flag-setting instruction and its operation
//   iOperandA/B, iResult  : ALU operands and result
//   iSave / iRestore      : copy live->shadow / shadow->live
//   oFlagN/Z/C/V          : registered live flags
//   oShadowValid          : shadow holds a saved value
//   oRestoreErr           : one-cycle pulse after a restore with no shadow
module nzcv_register
  import nzcv_register_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iEnable,
  input  logic             iSetFlags,
  input  logic [1:0]       iFlagOp,
  input  logic [WIDTH-1:0] iOperandA,
  input  logic [WIDTH-1:0] iOperandB,
  input  logic [WIDTH-1:0] iResult,
  input  logic             iSave,
  input  logic             iRestore,
  output logic             oFlagN,
  output logic             oFlagZ,
  output logic             oFlagC,
  output logic             oFlagV,
  output logic             oShadowValid,
  output logic             oRestoreErr
);

  nzcv_t calcFlags, liveFlags, shadowFlags, liveNext, shadowNext;
  logic  shadowValid, validNext, restoreErr, errNext;
  logic  doRestore, doUpdate;

  nzcv_calc #(.WIDTH(WIDTH)) uCalc (
    .iFlagOp   (iFlagOp),
    .iOperandA (iOperandA),
    .iOperandB (iOperandB),
    .iResult   (iResult),
    .oFlagN    (calcFlags.n),
    .oFlagZ    (calcFlags.z),
    .oFlagC    (calcFlags.c),
    .oFlagV    (calcFlags.v)
  );

  assign doRestore = iEnable & iRestore & shadowValid;
  assign doUpdate  = iEnable & iSetFlags & (iFlagOp != FLAG_OP_NONE);

  always_comb begin
    liveNext   = liveFlags;
    shadowNext = shadowFlags;
    validNext  = shadowValid;
    errNext    = 1'b0;
    // Save always sees the pre-update live value, so save+restore swaps.
    if (iEnable && iSave) begin
      shadowNext = liveFlags;
      validNext  = 1'b1;
    end
    if (doRestore) begin
      liveNext = shadowFlags;
      if (!iSave) validNext = 1'b0;
    end else begin
      errNext = iEnable & iRestore;
      if (doUpdate) liveNext = calcFlags;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      liveFlags   <= '0;
      shadowFlags <= '0;
      shadowValid <= 1'b0;
      restoreErr  <= 1'b0;
    end else begin
      liveFlags   <= liveNext;
      shadowFlags <= shadowNext;
      shadowValid <= validNext;
      restoreErr  <= errNext;
    end
  end

  assign oFlagN       = liveFlags.n;
  assign oFlagZ       = liveFlags.z;
  assign oFlagC       = liveFlags.c;
  assign oFlagV       = liveFlags.v;
  assign oShadowValid = shadowValid;
  assign oRestoreErr  = restoreErr;

endmodule
